// File: rtl/rcc_eth_pkg.sv
// Shared types and default timing constants for the ETH kernel-clock mode switch sequencer.
package rcc_eth_pkg;

   localparam int unsigned OFF_CYCLES_DEF    = 8;
   localparam int unsigned SETTLE_CYCLES_DEF = 16;
   localparam int unsigned CNT_W             = 5;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GATE_OFF = 2'd1,
      ST_SETTLE   = 2'd2
   } state_t;

endpackage

// File: rtl/rcc_eth_mode_switch_seq.sv
// Sequences an ETH speed/interface select change: gate kernel clocks, switch selects,
// let the new clock settle, then release the gates and pulse switch_done.
module rcc_eth_mode_switch_seq
   import rcc_eth_pkg::*;
#(
   parameter int unsigned OFF_CYCLES    = OFF_CYCLES_DEF,
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic i_clk,
   input  logic rst_n,
   input  logic req_valid,
   input  logic req_fes,
   input  logic req_epis_2,
   output logic req_ready,
   output logic eth_rcc_fes,
   output logic eth_rcc_epis_2,
   output logic eth_ker_clk_hold,
   output logic switch_done,
   output logic busy
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_fes_q, pend_fes_d;
   logic             pend_epis_q, pend_epis_d;
   logic             fes_q, fes_d;
   logic             epis_q, epis_d;
   logic             hold_q, hold_d;
   logic             done_q, done_d;

   // State and output registers, synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         pend_fes_q  <= 1'b0;
         pend_epis_q <= 1'b0;
         fes_q       <= 1'b0;
         epis_q      <= 1'b0;
         hold_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_fes_q  <= pend_fes_d;
         pend_epis_q <= pend_epis_d;
         fes_q       <= fes_d;
         epis_q      <= epis_d;
         hold_q      <= hold_d;
         done_q      <= done_d;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_fes_d  = pend_fes_q;
      pend_epis_d = pend_epis_q;
      fes_d       = fes_q;
      epis_d      = epis_q;
      hold_d      = hold_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            hold_d = 1'b0;
            if (req_valid) begin
               if ({req_fes, req_epis_2} == {fes_q, epis_q}) begin
                  done_d = 1'b1;
               end else begin
                  pend_fes_d  = req_fes;
                  pend_epis_d = req_epis_2;
                  state_d     = ST_GATE_OFF;
                  cnt_d       = CNT_W'(OFF_CYCLES - 1);
                  hold_d      = 1'b1;
               end
            end
         end
         ST_GATE_OFF: begin
            if (cnt_q == '0) begin
               // Gates have been off long enough; swap selects on this edge
               state_d = ST_SETTLE;
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
               fes_d   = pend_fes_q;
               epis_d  = pend_epis_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               hold_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            hold_d  = 1'b0;
         end
      endcase
   end

   assign req_ready        = (state_q == ST_IDLE);
   assign busy             = (state_q != ST_IDLE);
   assign eth_rcc_fes      = fes_q;
   assign eth_rcc_epis_2   = epis_q;
   assign eth_ker_clk_hold = hold_q;
   assign switch_done      = done_q;

endmodule

// File: tb/tb_rcc_eth_mode_switch_seq.sv
// Directed bench for rcc_eth_mode_switch_seq: default timing instance plus a 1/1 timing instance.
module tb_rcc_eth_mode_switch_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic a_valid = 1'b0, a_fes = 1'b0, a_epis = 1'b0;
   logic a_ready, a_sel_fes, a_sel_epis, a_hold, a_done, a_busy;
   logic b_valid = 1'b0, b_fes = 1'b0, b_epis = 1'b0;
   logic b_ready, b_sel_fes, b_sel_epis, b_hold, b_done, b_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rcc_eth_mode_switch_seq u_dut_a (
      .i_clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_fes(a_fes), .req_epis_2(a_epis),
      .req_ready(a_ready), .eth_rcc_fes(a_sel_fes), .eth_rcc_epis_2(a_sel_epis),
      .eth_ker_clk_hold(a_hold), .switch_done(a_done), .busy(a_busy)
   );

   rcc_eth_mode_switch_seq #(.OFF_CYCLES(1), .SETTLE_CYCLES(1)) u_dut_b (
      .i_clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_fes(b_fes), .req_epis_2(b_epis),
      .req_ready(b_ready), .eth_rcc_fes(b_sel_fes), .eth_rcc_epis_2(b_sel_epis),
      .eth_ker_clk_hold(b_hold), .switch_done(b_done), .busy(b_busy)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Packs {ready, busy, hold, done, fes, epis} for compact comparisons
   function automatic logic [7:0] pk_a();
      return {2'b00, a_ready, a_busy, a_hold, a_done, a_sel_fes, a_sel_epis};
   endfunction
   function automatic logic [7:0] pk_b();
      return {2'b00, b_ready, b_busy, b_hold, b_done, b_sel_fes, b_sel_epis};
   endfunction
   function automatic logic [7:0] ex(input logic r, bz, h, d, f, e);
      return {2'b00, r, bz, h, d, f, e};
   endfunction

   // Select-change guard: any change outside reset needs hold now and for OFF prior cycles
   logic [1:0] a_prev = 2'b00, b_prev = 2'b00;
   int         a_run = 0, b_run = 0;
   logic       rst_seen;
   always @(posedge clk) begin
      rst_seen = rst_n;
      #2;
      if (rst_seen === 1'b1) begin
         if ({a_sel_fes, a_sel_epis} !== a_prev) begin
            checks++;
            assert (a_hold === 1'b1 && a_run >= 8) else begin
               errors++;
               $error("FAIL a_sel_guard: observed hold=%0b run=%0d expected hold=1 run>=8", a_hold, a_run);
            end
         end
         if ({b_sel_fes, b_sel_epis} !== b_prev) begin
            checks++;
            assert (b_hold === 1'b1 && b_run >= 1) else begin
               errors++;
               $error("FAIL b_sel_guard: observed hold=%0b run=%0d expected hold=1 run>=1", b_hold, b_run);
            end
         end
      end
      a_prev = {a_sel_fes, a_sel_epis};
      b_prev = {b_sel_fes, b_sel_epis};
      a_run  = (a_hold === 1'b1) ? a_run + 1 : 0;
      b_run  = (b_hold === 1'b1) ? b_run + 1 : 0;
   end

   initial begin
      // Reset state
      rst_n = 1'b0;
      tick(); tick();
      check("reset_a", pk_a(), ex(1, 0, 0, 0, 0, 0));
      check("reset_b", pk_b(), ex(1, 0, 0, 0, 0, 0));
      rst_n = 1'b1;
      tick();

      // Switch to fes=1 with default timing
      a_valid = 1'b1; a_fes = 1'b1; a_epis = 1'b0;
      tick();
      a_valid = 1'b0;
      check("t1_c1", pk_a(), ex(0, 1, 1, 0, 0, 0));
      for (int c = 2; c <= 24; c++) begin
         tick();
         check($sformatf("t1_c%0d", c), pk_a(), ex(0, 1, 1, 0, logic'(c >= 9), 0));
      end
      tick();
      check("t1_c25", pk_a(), ex(1, 0, 0, 1, 1, 0));
      tick();
      check("t1_c26", pk_a(), ex(1, 0, 0, 0, 1, 0));

      // Request equal to current {0,0} after reset: done only
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("t2_reset", pk_a(), ex(1, 0, 0, 0, 0, 0));
      a_valid = 1'b1; a_fes = 1'b0; a_epis = 1'b0;
      tick();
      a_valid = 1'b0;
      check("t2_c1", pk_a(), ex(1, 0, 0, 1, 0, 0));
      tick();
      check("t2_c2", pk_a(), ex(1, 0, 0, 0, 0, 0));

      // epis-only change with req_valid held and inputs toggling while busy
      a_valid = 1'b1; a_fes = 1'b0; a_epis = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         tick();
         a_fes  = logic'(c % 2);
         a_epis = logic'((c / 2) % 2);
         check($sformatf("t3_ready_c%0d", c), {7'd0, a_ready}, 8'd0);
      end
      tick();
      a_valid = 1'b0;
      check("t3_c25", pk_a(), ex(1, 0, 0, 1, 0, 1));

      // Reset at cycle 12 of a switch to {1,1}
      tick();
      a_valid = 1'b1; a_fes = 1'b1; a_epis = 1'b1;
      tick();
      a_valid = 1'b0;
      for (int c = 2; c <= 12; c++) tick();
      check("t4_c12", pk_a(), ex(0, 1, 1, 0, 1, 1));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t4_c13", pk_a(), ex(1, 0, 0, 0, 0, 0));
      tick();
      check("t4_c14", pk_a(), ex(1, 0, 0, 0, 0, 0));
      a_valid = 1'b1; a_fes = 1'b1; a_epis = 1'b0;
      tick();
      a_valid = 1'b0;
      check("t4_new_c1", pk_a(), ex(0, 1, 1, 0, 0, 0));
      for (int c = 2; c <= 25; c++) tick();
      check("t4_new_c25", pk_a(), ex(1, 0, 0, 1, 1, 0));

      // OFF=1 SETTLE=1 instance: back-to-back {1,0} then {1,1}
      b_valid = 1'b1; b_fes = 1'b1; b_epis = 1'b0;
      tick();
      b_valid = 1'b0;
      check("t5_c1", pk_b(), ex(0, 1, 1, 0, 0, 0));
      tick();
      check("t5_c2", pk_b(), ex(0, 1, 1, 0, 1, 0));
      tick();
      check("t5_c3", pk_b(), ex(1, 0, 0, 1, 1, 0));
      b_valid = 1'b1; b_fes = 1'b1; b_epis = 1'b1;
      tick();
      b_valid = 1'b0;
      check("t5_c4", pk_b(), ex(0, 1, 1, 0, 1, 0));
      tick();
      check("t5_c5", pk_b(), ex(0, 1, 1, 0, 1, 1));
      tick();
      check("t5_c6", pk_b(), ex(1, 0, 0, 1, 1, 1));
      tick();
      check("t5_c7", pk_b(), ex(1, 0, 0, 0, 1, 1));

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rcc_eth_mode_switch_seq.md
RCC_ETH_MODE_SWITCH_SEQ -- requirements
Module: rcc_eth_mode_switch_seq

Interface
REQ-001 SHALL have parameter OFF_CYCLES, default 8, meaning cycles kernel clocks are held gated before the select change (legal range 1..31).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16, meaning cycles held after the select change before release (legal range 1..31).
REQ-003 SHALL have port i_clk  input  1  single clock for the block (RCC bus clock).
REQ-004 SHALL have port rst_n  input  1  reset, synchronous to i_clk, active-low.
REQ-005 SHALL have port req_valid  input  1  mode change request.
REQ-006 SHALL have port req_fes  input  1  requested speed (1 = 100M, /2 path; 0 = 10M, /20 path).
REQ-007 SHALL have port req_epis_2  input  1  requested interface (1 = RMII, 0 = MII).
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-009 SHALL have port eth_rcc_fes  output  1  speed select to the kernel clock control stage.
REQ-010 SHALL have port eth_rcc_epis_2  output  1  interface select to the kernel clock control stage.
REQ-011 SHALL have port eth_ker_clk_hold  output  1  force-off of all ETH kernel clock gates (ANDed downstream into the eth1rx/eth1tx enables).
REQ-012 SHALL have port switch_done  output  1  single-cycle completion pulse.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, GATE_OFF, SETTLE with a 5-bit down-counter cnt.
REQ-015 req_ready SHALL equal (state == IDLE); acceptance SHALL occur on req_valid & req_ready.
REQ-016 Accept in IDLE with {req_fes, req_epis_2} equal to current outputs: SHALL stay IDLE, hold stays 0, switch_done = 1 in the next cycle.
REQ-017 Accept in IDLE with a differing request: SHALL capture req_fes/req_epis_2 into pending registers, go to GATE_OFF, load cnt = OFF_CYCLES-1, assert hold from the next cycle.
REQ-018 GATE_OFF: cnt SHALL decrement each cycle; at cnt == 0, next state SETTLE, load cnt = SETTLE_CYCLES-1, and update eth_rcc_fes/eth_rcc_epis_2 from pending in the same edge.
REQ-019 SETTLE: cnt SHALL decrement each cycle; at cnt == 0, next state IDLE, hold = 0, switch_done = 1 for exactly one cycle.
REQ-020 Latency, acceptance at cycle 0: hold = 1 in cycles 1..OFF+SETTLE; new selects visible from cycle OFF+1; hold = 0, switch_done = 1, and req_ready = 1 at cycle OFF+SETTLE+1.
REQ-021 Selects SHALL change only while hold has been 1 for at least OFF_CYCLES full cycles, and never in the same cycle hold rises or falls.
REQ-022 req_valid while busy SHALL be back-pressured (req_ready = 0); request inputs SHALL be ignored and pending registers SHALL NOT change.
REQ-023 Request in the IDLE cycle immediately following switch_done SHALL be accepted normally (back-to-back).
REQ-024 Only the fes bit or only the epis_2 bit differing SHALL still run the full sequence.
REQ-025 switch_done and req_ready SHALL be registered or state-decoded with no combinational path from req_valid.

Reset
REQ-026 rst_n low at an i_clk edge SHALL force state IDLE, cnt = 0, pending = 0, eth_rcc_fes = 0, eth_rcc_epis_2 = 0, eth_ker_clk_hold = 0, switch_done = 0; busy = 0, req_ready = 1 after that edge.
REQ-027 Reset mid-sequence SHALL abort with no switch_done pulse; selects SHALL return to 0/0 regardless of pending values.
REQ-028 No asynchronous reset or clear paths SHALL exist.

Structure
REQ-029 State encoding typedef and default OFF/SETTLE constants SHALL live in shared package rcc_eth_pkg.
REQ-030 Single flat module, no sub-module; the counter SHALL be inline.

Verification
REQ-031 Reset then req {fes=1, epis_2=0} at cycle 0, defaults -> hold = 1 cycles 1..24; fes = 1 from cycle 9; done pulse and hold = 0 at cycle 25.
REQ-032 Request equal to current {0,0} -> no hold, switch_done at cycle 1, busy stays 0.
REQ-033 req_valid held high with changing values during sequence -> req_ready = 0 throughout; final selects equal the values captured at acceptance.
REQ-034 rst_n low at cycle 12 of a switch to {1,1} -> next cycle selects 0/0, hold 0, no done pulse; a new request is accepted afterwards.
REQ-035 OFF_CYCLES = 1, SETTLE_CYCLES = 1, back-to-back requests {1,0} then {1,1} -> per-request hold of 2 cycles, second accepted in the done cycle.
REQ-036 Assertion across all tests: any select change implies hold was 1 in the previous OFF_CYCLES cycles and in the change cycle.
